// File: rtl/msix_vector_engine_if.sv
// BAR memory channel between the BAR decoder (master) and the MSI-X engine (slave).
// One-cycle access strobe with byte write enables; read data returns with ack.
interface msix_vector_engine_if #(
    parameter int unsigned C_ADDR_WIDTH = 9
);
    logic                    en;
    logic [C_ADDR_WIDTH-1:0] addr;
    logic [63:0]             din;
    logic [7:0]              we;
    logic [63:0]             dout;
    logic                    ack;

    modport master (output en, addr, din, we, input dout, ack);
    modport slave  (input en, addr, din, we, output dout, ack);
endinterface

// File: rtl/msix_vector_engine.sv
// MSI-X controller: register-based vector table and PBA, irq detection, arbitration and
// cfg_interrupt_msix_* handshake with backoff. Define MSIX_LEVEL_IRQ_EN for level-sensitive irq.
module msix_vector_engine #(
    parameter int unsigned C_NUM_VECTORS       = 8,
    parameter int unsigned C_MSIX_TABLE_OFFSET = 9'h000,
    parameter int unsigned C_MSIX_PBA_OFFSET   = 9'h100,
    parameter int unsigned C_ADDR_WIDTH        = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    msix_vector_engine_if.slave      s_mem_iface,
    input  logic [1:0]               cfg_interrupt_msix_enable,
    input  logic [1:0]               cfg_interrupt_msix_mask,
    output logic [63:0]              cfg_interrupt_msix_address,
    output logic [31:0]              cfg_interrupt_msix_data,
    output logic                     cfg_interrupt_msix_int,
    input  logic                     cfg_interrupt_msix_sent,
    input  logic                     cfg_interrupt_msix_fail,
    input  logic [C_NUM_VECTORS-1:0] irq,
    output logic [C_NUM_VECTORS-1:0] pending_o
);

    localparam int unsigned IDX_W = (C_NUM_VECTORS > 1) ? $clog2(C_NUM_VECTORS) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOAD    = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_BACKOFF = 2'd3;

    logic [63:0]              tab_addr_q [C_NUM_VECTORS];
    logic [63:0]              tab_addr_d [C_NUM_VECTORS];
    logic [31:0]              tab_data_q [C_NUM_VECTORS];
    logic [31:0]              tab_data_d [C_NUM_VECTORS];
    logic [C_NUM_VECTORS-1:0] tab_mask_q, tab_mask_d;

    logic [C_NUM_VECTORS-1:0] pending_q, pending_d;
    logic [C_NUM_VECTORS-1:0] irq_set, pend_clr, eligible;
    logic [IDX_W-1:0]         sel_idx;
    logic                     any_elig;

    logic [1:0]               state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [3:0]               backoff_q, backoff_d;
    logic [63:0]              msg_addr_q, msg_addr_d;
    logic [31:0]              msg_data_q, msg_data_d;
    logic                     int_q, int_d;

    logic                     ack_q, ack_d;
    logic [63:0]              dout_q, dout_d;
    logic [63:0]              rdata;
    logic [31:0]              mem_a;

    // Only bit 0 of the function-level enable/mask belongs to this function.
    logic cfg_unused;
    assign cfg_unused = cfg_interrupt_msix_enable[1] ^ cfg_interrupt_msix_mask[1];

    assign mem_a = 32'(s_mem_iface.addr[C_ADDR_WIDTH-1:0]);

    // Read mux; PBA decode last so it takes priority if offsets ever overlap.
    always_comb begin
        rdata = '0;
        for (int unsigned k = 0; k < C_NUM_VECTORS; k++) begin
            if (mem_a == C_MSIX_TABLE_OFFSET + 2 * k)
                rdata = tab_addr_q[k];
            if (mem_a == C_MSIX_TABLE_OFFSET + 2 * k + 1)
                rdata = {31'b0, tab_mask_q[k], tab_data_q[k]};
        end
        if (mem_a == C_MSIX_PBA_OFFSET)
            rdata = 64'(pending_q);
    end

    always_comb begin
        ack_d  = s_mem_iface.en;
        dout_d = s_mem_iface.en ? rdata : '0;
    end

    always_comb begin
        tab_mask_d = tab_mask_q;
        for (int unsigned k = 0; k < C_NUM_VECTORS; k++) begin
            tab_addr_d[k] = tab_addr_q[k];
            tab_data_d[k] = tab_data_q[k];
            if (s_mem_iface.en && mem_a == C_MSIX_TABLE_OFFSET + 2 * k) begin
                for (int unsigned b = 0; b < 8; b++)
                    if (s_mem_iface.we[b])
                        tab_addr_d[k][8*b +: 8] = s_mem_iface.din[8*b +: 8];
            end
            if (s_mem_iface.en && mem_a == C_MSIX_TABLE_OFFSET + 2 * k + 1) begin
                for (int unsigned b = 0; b < 4; b++)
                    if (s_mem_iface.we[b])
                        tab_data_d[k][8*b +: 8] = s_mem_iface.din[8*b +: 8];
                if (s_mem_iface.we[4])
                    tab_mask_d[k] = s_mem_iface.din[32];
            end
        end
    end

`ifdef MSIX_LEVEL_IRQ_EN
    always_comb irq_set = irq;
`else
    logic [C_NUM_VECTORS-1:0] irq_prev_q, irq_prev_d;

    always_comb begin
        irq_prev_d = irq;
        irq_set    = irq & ~irq_prev_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq_prev_q <= '0;
        else     irq_prev_q <= irq_prev_d;
    end
`endif

    // Set is ORed in after the clear so a new edge survives a same-cycle sent.
    always_comb pending_d = (pending_q & ~pend_clr) | irq_set;

    always_comb begin
        eligible = pending_q & ~tab_mask_q &
                   {C_NUM_VECTORS{cfg_interrupt_msix_enable[0] & ~cfg_interrupt_msix_mask[0]}};
        any_elig = |eligible;
        sel_idx  = '0;
        for (int unsigned k = 0; k < C_NUM_VECTORS; k++)
            if (eligible[k]) sel_idx = IDX_W'(k);
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        backoff_d  = backoff_q;
        msg_addr_d = msg_addr_q;
        msg_data_d = msg_data_q;
        int_d      = 1'b0;
        pend_clr   = '0;
        case (state_q)
            ST_IDLE: begin
                if (any_elig) begin
                    idx_d   = sel_idx;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                for (int unsigned k = 0; k < C_NUM_VECTORS; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        msg_addr_d = tab_addr_q[k];
                        msg_data_d = tab_data_q[k];
                    end
                end
                int_d   = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cfg_interrupt_msix_sent) begin
                    for (int unsigned k = 0; k < C_NUM_VECTORS; k++)
                        if (idx_q == IDX_W'(k)) pend_clr[k] = 1'b1;
                    state_d = ST_IDLE;
                end else if (cfg_interrupt_msix_fail) begin
                    backoff_d = '0;
                    state_d   = ST_BACKOFF;
                end
            end
            ST_BACKOFF: begin
                backoff_d = backoff_q + 4'd1;
                if (backoff_q == 4'hF) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            backoff_q  <= '0;
            msg_addr_q <= '0;
            msg_data_q <= '0;
            int_q      <= 1'b0;
            pending_q  <= '0;
            ack_q      <= 1'b0;
            dout_q     <= '0;
            tab_mask_q <= '1;
            for (int unsigned k = 0; k < C_NUM_VECTORS; k++) begin
                tab_addr_q[k] <= '0;
                tab_data_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            backoff_q  <= backoff_d;
            msg_addr_q <= msg_addr_d;
            msg_data_q <= msg_data_d;
            int_q      <= int_d;
            pending_q  <= pending_d;
            ack_q      <= ack_d;
            dout_q     <= dout_d;
            tab_mask_q <= tab_mask_d;
            for (int unsigned k = 0; k < C_NUM_VECTORS; k++) begin
                tab_addr_q[k] <= tab_addr_d[k];
                tab_data_q[k] <= tab_data_d[k];
            end
        end
    end

    assign s_mem_iface.ack            = ack_q;
    assign s_mem_iface.dout           = dout_q;
    assign cfg_interrupt_msix_address = msg_addr_q;
    assign cfg_interrupt_msix_data    = msg_data_q;
    assign cfg_interrupt_msix_int     = int_q;
    assign pending_o                  = pending_q;

endmodule

// File: tb/tb_msix_vector_engine.sv
// Bench for msix_vector_engine: transaction-level model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_msix_vector_engine;

    localparam int N   = 8;
    localparam int TAB = 0;
    localparam int PBA = 256;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   msix_en, msix_mask;
    logic [63:0]  o_addr;
    logic [31:0]  o_data;
    logic         o_int, sent, fail;
    logic [N-1:0] irq, pend;

    always #5 clk = ~clk;

    msix_vector_engine_if #(.C_ADDR_WIDTH(9)) mem_if ();

    msix_vector_engine #(
        .C_NUM_VECTORS      (N),
        .C_MSIX_TABLE_OFFSET(TAB),
        .C_MSIX_PBA_OFFSET  (PBA),
        .C_ADDR_WIDTH       (9)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .s_mem_iface               (mem_if.slave),
        .cfg_interrupt_msix_enable (msix_en),
        .cfg_interrupt_msix_mask   (msix_mask),
        .cfg_interrupt_msix_address(o_addr),
        .cfg_interrupt_msix_data   (o_data),
        .cfg_interrupt_msix_int    (o_int),
        .cfg_interrupt_msix_sent   (sent),
        .cfg_interrupt_msix_fail   (fail),
        .irq                       (irq),
        .pending_o                 (pend)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0]  m_addr [N];
    logic [31:0]  m_data [N];
    logic [N-1:0] m_mask, m_pend, m_prev;
    bit           busy;
    int           sel, load_at, int_at, free_at, cyc;
    logic         e_ack;
    logic [63:0]  e_dout, e_maddr;
    logic [31:0]  e_mdata;

    function automatic logic [63:0] m_read(input int a);
        int k;
        if (a >= TAB && a < TAB + 2 * N) begin
            k = (a - TAB) / 2;
            if ((a - TAB) % 2 == 1) return {31'b0, m_mask[k], m_data[k]};
            return m_addr[k];
        end
        if (a == PBA) return 64'(m_pend);
        return 64'h0;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int i = 0; i < N; i++) begin m_addr[i] = '0; m_data[i] = '0; end
                m_mask = '1; m_pend = '0; m_prev = '0;
                busy = 0; sel = 0; load_at = -1; int_at = -1; free_at = 0; cyc = 0;
                e_ack = 0; e_dout = '0; e_maddr = '0; e_mdata = '0;
            end else begin
                logic [N-1:0] elig, set, clr;
                int a;
                clr = '0;
                if (busy && cyc == load_at) begin
                    e_maddr = m_addr[sel];
                    e_mdata = m_data[sel];
                end
                if (busy && cyc >= int_at) begin
                    if (sent) begin
                        clr[sel] = 1'b1; busy = 0; free_at = cyc + 1;
                    end else if (fail) begin
                        busy = 0; free_at = cyc + 17;
                    end
                end else if (!busy && cyc >= free_at) begin
                    elig = m_pend & ~m_mask & {N{msix_en[0] & ~msix_mask[0]}};
                    if (elig != '0) begin
                        for (int i = 0; i < N; i++) if (elig[i]) sel = i;
                        busy = 1; load_at = cyc + 1; int_at = cyc + 2;
                    end
                end
                a      = int'(mem_if.addr);
                e_ack  = mem_if.en;
                e_dout = mem_if.en ? m_read(a) : 64'h0;
                if (mem_if.en && a >= TAB && a < TAB + 2 * N) begin
                    int k;
                    k = (a - TAB) / 2;
                    for (int b = 0; b < 8; b++) begin
                        if (mem_if.we[b]) begin
                            if ((a - TAB) % 2 == 0) m_addr[k][8*b +: 8] = mem_if.din[8*b +: 8];
                            else if (b < 4)         m_data[k][8*b +: 8] = mem_if.din[8*b +: 8];
                            else if (b == 4)        m_mask[k] = mem_if.din[32];
                        end
                    end
                end
`ifdef MSIX_LEVEL_IRQ_EN
                set = irq;
`else
                set = irq & ~m_prev;
`endif
                m_prev = irq;
                m_pend = (m_pend & ~clr) | set;
                cyc++;
            end
            #1;
            check("mdl_ack",  64'(mem_if.ack), 64'(e_ack));
            check("mdl_dout", mem_if.dout, e_dout);
            check("mdl_int",  64'(o_int), 64'(cyc == int_at));
            check("mdl_addr", o_addr, e_maddr);
            check("mdl_data", 64'(o_data), 64'(e_mdata));
            check("mdl_pend", 64'(pend), 64'(m_pend));
        end
    end

    // ---------------- stimulus (all tasks start and end on a negedge) ----------------
    task automatic mem_write(input int a, input logic [63:0] d, input logic [7:0] be);
        mem_if.en = 1'b1; mem_if.addr = 9'(a); mem_if.din = d; mem_if.we = be;
        @(negedge clk);
        mem_if.en = 1'b0; mem_if.we = '0;
    endtask

    task automatic mem_read(input string name, input int a, input logic [63:0] exp);
        mem_if.en = 1'b1; mem_if.addr = 9'(a); mem_if.we = '0;
        @(negedge clk);
        mem_if.en = 1'b0;
        check({name, "_ack"}, 64'(mem_if.ack), 64'h1);
        check(name, mem_if.dout, exp);
    endtask

    task automatic wait_int(input string name, input int limit);
        bit ok;
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            if (o_int === 1'b1) begin ok = 1; break; end
            @(negedge clk);
        end
        check({name, "_int_seen"}, 64'(ok), 64'h1);
    endtask

    task automatic pulse_irq(input logic [N-1:0] v);
        irq = v;
        @(negedge clk);
        irq = '0;
    endtask

    task automatic respond(input bit s, input bit f);
        sent = s; fail = f;
        @(negedge clk);
        sent = 0; fail = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        time t1;
        int  gap;
        rst = 1'b1; mem_if.en = 0; mem_if.addr = '0; mem_if.din = '0; mem_if.we = '0;
        msix_en = 2'b00; msix_mask = 2'b00; sent = 0; fail = 0; irq = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_int",  64'(o_int), 64'h0);
        check("rst_pend", 64'(pend), 64'h0);
        check("rst_ack",  64'(mem_if.ack), 64'h0);
        check("rst_addr", o_addr, 64'h0);

        mem_read("rd_tab1_reset", TAB + 1, 64'h0000_0001_0000_0000);
        mem_read("rd_pba_reset", PBA, 64'h0);
        mem_write(PBA, '1, 8'hFF);
        mem_read("rd_pba_ro", PBA, 64'h0);
        mem_write(9'h1FF, '1, 8'hFF);
        mem_read("rd_unmapped", 9'h1FF, 64'h0);

        // vector 3: latency and sent
        mem_write(TAB + 6, 64'hFEE0_0000_1234_5000, 8'hFF);
        mem_write(TAB + 7, 64'h0000_0000_0000_4021, 8'hFF);
        mem_read("rd_v3_ctrl", TAB + 7, 64'h0000_0000_0000_4021);
        msix_en = 2'b01;
        pulse_irq(8'h08);
        check("v3_pend_c1", 64'(pend), 64'h08);
        @(negedge clk);
        check("v3_int_c2", 64'(o_int), 64'h0);
        @(negedge clk);
        check("v3_int_c3",  64'(o_int), 64'h1);
        check("v3_addr",    o_addr, 64'hFEE0_0000_1234_5000);
        check("v3_data",    64'(o_data), 64'h4021);
        respond(1, 0);
        check("v3_int_c4",  64'(o_int), 64'h0);
        check("v3_pend_clr", 64'(pend), 64'h0);

        // vectors 2 and 5 together; mask toggle while 5 is in flight
        mem_write(TAB + 4,  64'hFEE0_0000_0000_2000, 8'hFF);
        mem_write(TAB + 5,  64'h0000_0000_0000_0022, 8'hFF);
        mem_write(TAB + 10, 64'hFEE0_0000_0000_5000, 8'hFF);
        mem_write(TAB + 11, 64'h0000_0000_0000_0055, 8'hFF);
        pulse_irq(8'h24);
        wait_int("v5", 10);
        check("v5_first_data", 64'(o_data), 64'h55);
        msix_mask = 2'b01;
        respond(1, 0);
        repeat (3) @(negedge clk);
        check("v2_held_masked", 64'(pend), 64'h04);
        msix_mask = 2'b00;
        wait_int("v2", 10);
        check("v2_second_data", 64'(o_data), 64'h22);
        check("v2_second_addr", o_addr, 64'hFEE0_0000_0000_2000);
        respond(1, 0);
        check("v25_pend_clr", 64'(pend), 64'h0);

        // vector 1 masked, then unmasked with a byte-4-only write
        mem_write(TAB + 2, 64'hFEE0_0000_0000_1000, 8'hFF);
        mem_write(TAB + 3, 64'h0000_0000_0000_0011, 8'h0F);
        pulse_irq(8'h02);
        repeat (4) @(negedge clk);
        check("v1_masked_pend", 64'(pend), 64'h02);
        check("v1_masked_int",  64'(o_int), 64'h0);
        mem_write(TAB + 3, 64'h0, 8'h10);
        wait_int("v1_unmask", 3);
        check("v1_data", 64'(o_data), 64'h11);
        respond(1, 0);

        // vector 4 fail then retry after backoff
        mem_write(TAB + 8, 64'hFEE0_0000_0000_4000, 8'hFF);
        mem_write(TAB + 9, 64'h0000_0000_0000_0044, 8'hFF);
        pulse_irq(8'h10);
        wait_int("v4_first", 10);
        t1 = $time;
        respond(0, 1);
        check("v4_pend_kept", 64'(pend), 64'h10);
        wait_int("v4_retry", 40);
        gap = int'(($time - t1) / 10);
        check("v4_backoff_gap_ok", 64'(gap >= 17 && gap <= 20), 64'h1);
        check("v4_retry_data", 64'(o_data), 64'h44);
        respond(1, 1);
        check("v4_pend_clr", 64'(pend), 64'h0);

        // reset while waiting for sent
        pulse_irq(8'h08);
        wait_int("v3_again", 10);
        #1 rst = 1'b1;
        #1;
        check("arst_int",  64'(o_int), 64'h0);
        check("arst_pend", 64'(pend), 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mem_read("rd_v3_ctrl_after_rst", TAB + 7, 64'h0000_0001_0000_0000);
        mem_read("rd_v3_addr_after_rst", TAB + 6, 64'h0);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/msix_vector_engine.md
Name: msix_vector_engine

Overview:
- Parametrised MSI-X controller holding an N-vector MSI-X table and PBA in registers.
- Host accesses the table and PBA through the BAR memory channel.
- Edge- or level-detects up to N interrupt inputs and arbitrates pending vectors.
- Drives the integrated PCIe block's cfg_interrupt_msix_* handshake, retrying on fail. Sits between the BAR decoder and the PCIe hard block's config interrupt port.

Parameters:
C_NUM_VECTORS, 8, number of MSI-X vectors/irq inputs (1..32)
C_MSIX_TABLE_OFFSET, 9'h000, qword address of table entry 0
C_MSIX_PBA_OFFSET, 9'h100, qword address of the PBA qword
C_ADDR_WIDTH, 9, memory channel qword address width

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
s_mem_iface_en  in  1  access strobe, one cycle per access
s_mem_iface_addr  in  C_ADDR_WIDTH  qword address
s_mem_iface_din  in  64  write data
s_mem_iface_we  in  8  byte write enables; 0 = read
s_mem_iface_dout  out  64  read data, valid with ack
s_mem_iface_ack  out  1  access completion
cfg_interrupt_msix_enable  in  2  function MSI-X enable; bit0 used
cfg_interrupt_msix_mask  in  2  function mask; bit0 used
cfg_interrupt_msix_address  out  64  message address
cfg_interrupt_msix_data  out  32  message data
cfg_interrupt_msix_int  out  1  request pulse
cfg_interrupt_msix_sent  in  1  message sent
cfg_interrupt_msix_fail  in  1  message failed
irq  in  C_NUM_VECTORS  interrupt sources, sync to clk
pending_o  out  C_NUM_VECTORS  PBA mirror for debug

Behaviour:
- Reset values:
  - All outputs 0.
  - Table addr/data 0; vector-control mask bit = 1 (all vectors masked).
  - PBA 0; FSM in IDLE.
- Table layout, entry k:
  - Qword TABLE+2k = {addr_hi, addr_lo}.
  - Qword TABLE+2k+1 = {vector_ctrl, msg_data}; mask = bit 32. Vector-control bits other than mask read 0, writes ignored.
- Byte enables apply per byte.
- Memory channel:
  - ack = en delayed 1 cycle; dout registered, valid on the ack cycle, otherwise 0.
  - PBA qword reads {0, pending}; writes to the PBA are ignored.
  - Unmapped addresses read 0 and ignore writes, but are still acked.
- Pending set: rising edge of irq[k] (previous-cycle register, reset 0) sets pending[k] the next cycle. Set wins over a same-cycle clear.
- Eligible vector: pending AND vector mask=0, while enable[0]=1 and mask[0]=0. Masked or disabled vectors stay pending.
- Arbitration: highest eligible index wins.
- FSM:
  - IDLE: if any vector is eligible, latch its index -> LOAD.
  - LOAD: latch the entry's addr/data onto the outputs; assert int for exactly one cycle -> WAIT.
  - WAIT: on sent, clear pending[idx] -> IDLE. On fail, keep pending -> BACKOFF.
  - BACKOFF: wait 16 cycles (4-bit counter) -> IDLE, then re-arbitrate.
  - In WAIT, sent and fail together count as sent.
- Outputs address/data hold their last latched value until the next LOAD. Host writes to the table during WAIT do not change them.
- Latency: irq edge at cycle 0 -> pending at 1 -> IDLE select at 2 -> int high at cycle 3.
- Mask or enable change during WAIT: the in-flight request completes normally.
- Reset mid-operation: int drops immediately; pending and table are cleared to reset values.

Optional Feature:
MSIX_LEVEL_IRQ_EN
- Defined: irq is level-sensitive. pending[k] is set every cycle irq[k]=1, so a vector re-fires after sent while its source stays high.
- Undefined: rising-edge detection only, as described above.

Test Plan:
- Reset, then read qword TABLE+1 -> ack 1 cycle after en, dout=64'h0000_0001_0000_0000; read PBA -> 0.
- Program vector 3 (addr 64'hFEE0_0000_1234_5000, data 32'h0000_4021, mask 0), enable=1, pulse irq[3] at cycle 0 -> int pulse at cycle 3 with that addr/data; sent -> PBA bit3 clears.
- irq[2] and irq[5] edges in the same cycle, both unmasked -> vector 5 is sent first, then 2; int is never asserted while in WAIT.
- Vector 1 masked, irq[1] edge -> PBA=0x2 and no int; clear the mask -> int for vector 1 within 3 cycles.
- Respond fail to vector 4 -> pending is kept, int re-issued 16+ cycles later; then sent -> pending clears.
- Assert rst during WAIT -> int=0 and pending=0 asynchronously; table mask bits read 1 after release.
